// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered read port and registered full/empty flags.
// Storage is a plain array. Separate read and write pointers wrap explicitly at
// DATA_DEPTH - 1, so the depth does not have to be a power of two.
//
// Request semantics: write/read are level requests sampled on each rising edge.
// A write is accepted only when full_flag is 0 before that edge, and a read only
// when empty_flag is 0. A rejected request has no effect at all.
// data_out changes only on an edge that accepts a read. It then shows the oldest
// stored word, so read latency is one edge.
module sync_fifo #(
    parameter int DATA_WITH  = 16,
    parameter int DATA_DEPTH = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 write,
    input  logic                 read,
    input  logic [DATA_WITH-1:0] data_in,
    output logic                 empty_flag,
    output logic                 full_flag,
    output logic [DATA_WITH-1:0] data_out
);

    localparam int PTR_W = (DATA_DEPTH > 1) ? $clog2(DATA_DEPTH) : 1;
    localparam int CNT_W = $clog2(DATA_DEPTH) + 1;

    localparam logic [PTR_W-1:0] LAST_PTR  = PTR_W'(DATA_DEPTH - 1);
    localparam logic [CNT_W-1:0] FULL_CNT  = CNT_W'(DATA_DEPTH);
    localparam logic [CNT_W-1:0] ZERO_CNT  = '0;
    localparam logic [CNT_W-1:0] ONE_CNT   = CNT_W'(1);
    localparam logic [PTR_W-1:0] ONE_PTR   = PTR_W'(1);

    logic [DATA_WITH-1:0] mem [DATA_DEPTH];

    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;

    logic             write_ok;
    logic             read_ok;
    logic [PTR_W-1:0] wr_ptr_next;
    logic [PTR_W-1:0] rd_ptr_next;
    logic [CNT_W-1:0] count_next;

    // Acceptance uses the registered flags. Next pointers wrap at the last entry.
    // The next count feeds both the count register and the flag registers.
    always_comb begin
        write_ok    = write & ~full_flag;
        read_ok     = read & ~empty_flag;
        wr_ptr_next = wr_ptr;
        rd_ptr_next = rd_ptr;
        count_next  = count;

        if (write_ok) begin
            wr_ptr_next = (wr_ptr == LAST_PTR) ? '0 : wr_ptr + ONE_PTR;
        end
        if (read_ok) begin
            rd_ptr_next = (rd_ptr == LAST_PTR) ? '0 : rd_ptr + ONE_PTR;
        end

        // A write and a read accepted on the same edge leave the occupancy unchanged.
        if (write_ok && !read_ok) begin
            count_next = count + ONE_CNT;
        end else if (read_ok && !write_ok) begin
            count_next = count - ONE_CNT;
        end
    end

    // Pointers, occupancy and flags. Reset discards the contents logically.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            empty_flag <= 1'b1;
            full_flag  <= 1'b0;
        end else begin
            wr_ptr     <= wr_ptr_next;
            rd_ptr     <= rd_ptr_next;
            count      <= count_next;
            empty_flag <= (count_next == ZERO_CNT);
            full_flag  <= (count_next == FULL_CNT);
        end
    end

    // Storage write. The array has no reset; stale entries are never read.
    always_ff @(posedge clk) begin
        if (!rst && write_ok) begin
            mem[wr_ptr] <= data_in;
        end
    end

    // Registered read port. It loads only on an accepted read and holds otherwise.
    always_ff @(posedge clk) begin
        if (rst) begin
            data_out <= '0;
        end else if (read_ok) begin
            data_out <= mem[rd_ptr];
        end
    end

endmodule

// File: tb/tb_sync_fifo.sv
// Self-checking bench for sync_fifo.
// A reference model of occupancy and flags runs alongside the DUT. Accepted
// writes push their data onto exp_q, and accepted reads pop the expected
// data_out from it.
module tb_sync_fifo;

    localparam int W     = 16;
    localparam int DEPTH = 32;

    // ---------------- clock / reset ----------------
    logic         clk = 1'b0;
    logic         rst;
    logic         write;
    logic         read;
    logic [W-1:0] data_in;
    logic         empty_flag;
    logic         full_flag;
    logic [W-1:0] data_out;

    always #5 clk = ~clk;

    sync_fifo #(
        .DATA_WITH (W),
        .DATA_DEPTH(DEPTH)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .write     (write),
        .read      (read),
        .data_in   (data_in),
        .empty_flag(empty_flag),
        .full_flag (full_flag),
        .data_out  (data_out)
    );

    // ---------------- scoreboard / model ----------------
    logic [W-1:0] exp_q[$];
    int           model_cnt;
    logic [W-1:0] model_dout;
    int           n_checks;
    int           n_pass;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_outputs(input string tag);
        check_val({tag, ".empty"}, 32'(empty_flag), 32'(model_cnt == 0));
        check_val({tag, ".full"},  32'(full_flag),  32'(model_cnt == DEPTH));
        check_val({tag, ".dout"},  32'(data_out),   32'(model_dout));
    endtask

    // ---------------- driver tasks ----------------
    // Inputs are applied 1 time unit after an edge. Outputs are checked 1 time
    // unit after the next edge.
    task automatic drive(input string tag, input logic w, input logic r, input logic [W-1:0] d);
        bit w_ok;
        bit r_ok;
        w_ok    = w && (model_cnt != DEPTH);
        r_ok    = r && (model_cnt != 0);
        write   = w;
        read    = r;
        data_in = d;
        @(posedge clk);
        #1;
        if (r_ok) model_dout = exp_q.pop_front();
        if (w_ok) exp_q.push_back(d);
        model_cnt = model_cnt + (w_ok ? 1 : 0) - (r_ok ? 1 : 0);
        write = 1'b0;
        read  = 1'b0;
        check_outputs(tag);
    endtask

    task automatic apply_reset(input int cycles);
        rst   = 1'b1;
        write = 1'b1;
        read  = 1'b1;
        data_in = 16'hdead;
        repeat (cycles) @(posedge clk);
        #1;
        rst   = 1'b0;
        write = 1'b0;
        read  = 1'b0;
        exp_q.delete();
        model_cnt  = 0;
        model_dout = '0;
        check_outputs("reset");
    endtask

    // ---------------- stimulus ----------------
    initial begin
        n_checks   = 0;
        n_pass     = 0;
        model_cnt  = 0;
        model_dout = '0;
        rst        = 1'b1;
        write      = 1'b0;
        read       = 1'b0;
        data_in    = '0;

        // Reset held with both requests active.
        apply_reset(4);

        // Fill. empty falls after the first edge, full rises after the 32nd, and data_out stays 0.
        for (int i = 1; i <= DEPTH; i++) drive("fill", 1'b1, 1'b0, W'(i));

        // Overflow. The write while full is dropped.
        drive("overflow", 1'b1, 1'b0, W'(33));

        // Drain. The FIFO must return 1..32 only.
        for (int i = 1; i <= DEPTH; i++) drive("drain", 1'b0, 1'b1, '0);

        // Underflow. data_out holds 32.
        for (int i = 0; i < 3; i++) drive("underflow", 1'b0, 1'b1, '0);
        check_val("underflow.hold32", 32'(data_out), 32'd32);

        // Write and read together on an empty FIFO. Only the write is accepted.
        drive("wr_rd_empty", 1'b1, 1'b1, W'(16'h0100));
        check_val("wr_rd_empty.dout_held", 32'(data_out), 32'd32);
        drive("wr_rd_empty.read", 1'b0, 1'b1, '0);

        // Five words stored, then simultaneous write and read.
        for (int i = 0; i < 5; i++) drive("five.fill", 1'b1, 1'b0, W'(16'h0200 + i));
        for (int i = 0; i < 8; i++) drive("five.both", 1'b1, 1'b1, W'(16'h0300 + i));
        check_val("five.count", 32'(exp_q.size()), 32'd5);
        for (int i = 0; i < 5; i++) drive("five.drain", 1'b0, 1'b1, '0);

        // Pointer wrap: write 20, read 20, write 32 (full), then drain 32.
        for (int i = 0; i < 20; i++) drive("wrap.w20", 1'b1, 1'b0, W'($urandom_range(0, 16'hffff)));
        for (int i = 0; i < 20; i++) drive("wrap.r20", 1'b0, 1'b1, '0);
        for (int i = 0; i < DEPTH; i++) drive("wrap.w32", 1'b1, 1'b0, W'($urandom_range(0, 16'hffff)));
        drive("wrap.full_rw", 1'b1, 1'b1, W'(16'hbeef));
        drive("wrap.refill", 1'b1, 1'b0, W'(16'h4444));
        for (int i = 0; i < DEPTH; i++) drive("wrap.drain", 1'b0, 1'b1, '0);

        // Random mixed traffic.
        for (int i = 0; i < 200; i++)
            drive("random", 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  W'($urandom_range(0, 16'hffff)));

        // Reset in mid-operation with 10 words stored.
        apply_reset(1);
        for (int i = 0; i < 10; i++) drive("mid.fill", 1'b1, 1'b0, W'(16'h0500 + i));
        apply_reset(1);
        drive("mid.write", 1'b1, 1'b0, W'(16'h0abc));
        drive("mid.read", 1'b0, 1'b1, '0);
        check_val("mid.newword", 32'(data_out), 32'h0abc);

        // ---------------- final report ----------------
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
